// File: rtl/series_engine_arbiter.sv
// Round-robin arbiter sharing one start/done series engine among N requesters.
// Each grant runs ISSUE -> BUSY -> RESP, guarded by a BUSY-cycle watchdog.
module series_engine_arbiter #(
  parameter int N       = 4,
  parameter int XW      = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*XW-1:0] x_in,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    ack,
  output logic [RW-1:0]   result,
  output logic            err,
  output logic            busy,
  output logic            eng_start,
  output logic [XW-1:0]   eng_x,
  input  logic            eng_done,
  input  logic [RW-1:0]   eng_result
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  // Handshake: req is a level held by the client until its one-cycle ack;
  // eng_start is a one-cycle pulse, eng_done is a level and eng_result is
  // only meaningful while eng_done is high.
  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] pick;
  logic          found;
  logic [TW-1:0] timer;
  logic          left;
  logic [N-1:0]  sel_oh;

  // First pending requester at or after ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      sel    <= '0;
      timer  <= '0;
      left   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      eng_x  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            eng_x <= x_in[int'(pick)*XW +: XW];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          left  <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          // Done only counts after it has been seen low once since start,
          // so an engine idling with done high cannot complete early.
          if (!eng_done) left <= 1'b1;
          if (eng_done && left) begin
            result <= eng_result;
            err    <= 1'b0;
            state  <= RESP;
          end else if (timer == TW'(TIMEOUT)) begin
            result <= '0;
            err    <= 1'b1;
            state  <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          ptr   <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_oh    = {{(N-1){1'b0}}, 1'b1} << sel;
  assign grant     = (state != IDLE) ? sel_oh : '0;
  assign ack       = (state == RESP) ? sel_oh : '0;
  assign busy      = (state != IDLE);
  assign eng_start = (state == ISSUE);

endmodule

// File: doc/series_engine_arbiter.md
Name: series_engine_arbiter

Overview:
- Shares one series-evaluation engine (start/done controller plus t/r/counter datapath) among N requesters.
- Each requester presents an operand x and raises req.
- The arbiter grants the requesters round-robin, loads the winner's x, pulses the engine start, waits for completion with a watchdog, and returns the result with a one-cycle ack.
- It sits between the client blocks and the single engine instance.

Parameters:
N, 4, number of requesters (2..8)
XW, 8, operand width
RW, 16, engine result width
TIMEOUT, 255, max cycles in BUSY before abort; timer width = clog2(TIMEOUT+1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request per requester; level, held until ack
x_in  input  N*XW  operands; slice i = x_in[i*XW +: XW]
grant  output  N  one-hot owner of the engine; 0 when idle
ack  output  N  one-hot, one-cycle completion pulse to owner
result  output  RW  returned value; valid in ack cycle, held until next RESP
err  output  1  1 = transaction aborted by timeout; valid with ack
busy  output  1  state != IDLE
eng_start  output  1  start pulse to engine
eng_x  output  XW  registered operand to engine, stable from ISSUE to next load
eng_done  input  1  engine done, level
eng_result  input  RW  engine result, valid while eng_done=1

Behaviour:
- Reset (any state, including mid-transaction) forces these values next edge:
  - state=IDLE, ptr=0, sel=0, timer=0, left=0
  - grant=0, ack=0, result=0, err=0, eng_x=0, eng_start=0, busy=0
  - An in-flight engine run is abandoned; no ack is issued.
- FSM has four states: IDLE, ISSUE, BUSY, RESP. Outputs are Moore-decoded from state and registers.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... mod N.
  - Register sel and eng_x <= x_in slice sel; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - eng_start=1 for exactly this one cycle.
  - Clear timer and left; go to BUSY.
- BUSY:
  - timer increments each cycle.
  - left sets when eng_done is sampled 0. This covers engines that hold done high while idle and drop it after start.
  - Completion = eng_done=1 with left=1. On completion: result <= eng_result, err <= 0, go to RESP.
  - Else if timer == TIMEOUT: result <= 0, err <= 1, go to RESP.
  - Completion takes priority over timeout in the same cycle.
- RESP:
  - ack[sel]=1 for this one cycle.
  - ptr <= (sel+1) mod N, wrapping from N-1 to 0; go to IDLE.
- grant[sel]=1 in ISSUE, BUSY and RESP; grant=0 in IDLE.
- Latency:
  - req sampled in IDLE at edge k → eng_start high during cycle k+1.
  - Completion sampled at edge m → ack high during cycle m+1.
  - Minimum idle gap between transactions is 1 cycle (the IDLE arbitration cycle).
- req changes outside IDLE are ignored.
  - A requester dropping req mid-transaction still receives ack/result.
  - x_in changes after the IDLE load edge do not affect eng_x.
- A requester still holding req in the IDLE cycle after its ack is treated as a new request. Round-robin gives every other pending requester priority first.
- Simultaneous requests: exactly one grant; the others wait, with no starvation (each waits at most N-1 transactions).
- result and err hold their values between RESP states.

Test Plan:
1. N=4, reset then req=0001, x_in slice0=8'h05, engine drops done 2 cycles after start and returns done with 16'h1234 after 6 cycles → eng_start 1 cycle after req, eng_x=8'h05, grant=0001 through RESP, ack=0001 one cycle, result=16'h1234, err=0.
2. req=1111 held continuously, each engine run 4 cycles → grants in order 0001,0010,0100,1000,0001 (ptr wrap from 3 to 0), one ack each, an IDLE cycle between transactions.
3. TIMEOUT=15, engine never asserts done → ack 1 cycle after timer reaches 15, err=1, result=16'h0000, next request then served normally.
4. Engine holds done=1 throughout with no low cycle → not accepted as completion, timeout path taken, err=1.
5. rst pulsed in BUSY for requester 2 → all outputs 0 next cycle, no ack[2], ptr=0, so with req=0101 requester 0 is granted first.
6. Requester 1 drops req and changes x_in mid-BUSY → eng_x unchanged, ack=0010 still pulses with the engine result; completion and timeout in the same cycle → err=0.
